// File: rtl/apb_multi_timer.sv
// APB-attached bank of NUM_CH independent down-counting timers with prescalers,
// periodic/one-shot modes, sticky expiry status and per-channel interrupts.
module apb_multi_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] IRQ,
  output logic              irq_o
);

  localparam int unsigned WordW = ADDR_W - 2;
  localparam int unsigned ChW   = ADDR_W - 4;
  localparam logic [WordW-1:0] GlobWord = WordW'(NUM_CH * 4);

  logic [WordW-1:0] word_addr;
  logic [ChW-1:0]   ch_idx;
  logic [1:0]       reg_idx;
  logic             addr_err, is_glob, wr_acc, rd_setup;
  logic             unused_addr;

  assign word_addr   = PADDR[ADDR_W-1:2];
  assign ch_idx      = PADDR[ADDR_W-1:4];
  assign reg_idx     = PADDR[3:2];
  assign unused_addr = ^PADDR[1:0];
  assign addr_err    = word_addr > GlobWord;
  assign is_glob     = word_addr == GlobWord;
  assign wr_acc      = PSEL & PENABLE & PWRITE & ~addr_err;
  assign rd_setup    = PSEL & ~PENABLE & ~PWRITE;

  logic [NUM_CH-1:0] en_q, en_d, mode_q, mode_d, ie_q, ie_d, exp_q, exp_d;
  logic [3:0]        psc_q  [NUM_CH];
  logic [3:0]        psc_d  [NUM_CH];
  logic [3:0]        pcnt_q [NUM_CH];
  logic [3:0]        pcnt_d [NUM_CH];
  logic [CNT_W-1:0]  load_q [NUM_CH];
  logic [CNT_W-1:0]  load_d [NUM_CH];
  logic [CNT_W-1:0]  val_q  [NUM_CH];
  logic [CNT_W-1:0]  val_d  [NUM_CH];
  logic [31:0]       load_wdata [NUM_CH];
  logic [NUM_CH-1:0] ch_wr, tick;
  logic [31:0]       prdata_q, prdata_d, rdata;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr[i] = wr_acc && (ch_idx == ChW'(i));
      // Ticking on >= keeps a prescaler that was lowered mid-count from wrapping through 15.
      tick[i]  = en_q[i] && (pcnt_q[i] >= psc_q[i]);
      load_wdata[i] = 32'(load_q[i]);
      for (int b = 0; b < 4; b++) begin
        if (PSTRB[b]) load_wdata[i][8*b +: 8] = PWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    ie_d   = ie_q;
    exp_d  = exp_q;
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    load_d = load_q;
    val_d  = val_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // Clear first so an expiry on the same edge overrides it.
      if (ch_wr[i] && reg_idx == 2'd3 && PSTRB[0] && PWDATA[0]) exp_d[i] = 1'b0;
      if (en_q[i]) pcnt_d[i] = tick[i] ? 4'd0 : pcnt_q[i] + 4'd1;
      if (tick[i]) begin
        if (val_q[i] != '0) begin
          val_d[i] = val_q[i] - CNT_W'(1);
        end else begin
          exp_d[i] = 1'b1;
          if (mode_q[i]) en_d[i] = 1'b0;
          else           val_d[i] = load_q[i];
        end
      end
      if (ch_wr[i] && reg_idx == 2'd0) begin
        if (PSTRB[0]) begin
          en_d[i]   = PWDATA[0];
          mode_d[i] = PWDATA[1];
          ie_d[i]   = PWDATA[2];
          if (!en_q[i] && PWDATA[0]) begin
            val_d[i]  = load_q[i];
            pcnt_d[i] = 4'd0;
          end
        end
        if (PSTRB[1]) psc_d[i] = PWDATA[11:8];
      end
      if (ch_wr[i] && reg_idx == 2'd2) begin
        load_d[i] = load_wdata[i][CNT_W-1:0];
        if (!en_q[i]) val_d[i] = load_wdata[i][CNT_W-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (is_glob) begin
      rdata = 32'(IRQ);
    end else if (!addr_err) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == ChW'(i)) begin
          case (reg_idx)
            2'd0:    rdata = {20'b0, psc_q[i], 5'b0, ie_q[i], mode_q[i], en_q[i]};
            2'd1:    rdata = 32'(val_q[i]);
            2'd2:    rdata = 32'(load_q[i]);
            default: rdata = {31'b0, exp_q[i]};
          endcase
        end
      end
    end
    prdata_d = rd_setup ? rdata : prdata_q;
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      en_q     <= '0;
      mode_q   <= '0;
      ie_q     <= '0;
      exp_q    <= '0;
      prdata_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        psc_q[i]  <= '0;
        pcnt_q[i] <= '0;
        load_q[i] <= '0;
        val_q[i]  <= '0;
      end
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
      prdata_q <= prdata_d;
      for (int i = 0; i < NUM_CH; i++) begin
        psc_q[i]  <= psc_d[i];
        pcnt_q[i] <= pcnt_d[i];
        load_q[i] <= load_d[i];
        val_q[i]  <= val_d[i];
      end
    end
  end

  assign IRQ     = exp_q & ie_q;
  assign irq_o   = |IRQ;
  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & addr_err;

endmodule

// File: doc/apb_multi_timer.md
APB_MULTI_TIMER -- requirements
Module: apb_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (legal 1..8).
REQ-002 Parameter CNT_W, default 32, counter and LOAD width in bits (legal 8..32).
REQ-003 Parameter ADDR_W, default 12, width of PADDR.
REQ-004 PCLK  input  1  single clock; all state updates on rising edge.
REQ-005 PRESET_n  input  1  asynchronous, active-low reset.
REQ-006 PSEL, PENABLE, PWRITE  input  1 each  APB select, access phase and direction.
REQ-007 PADDR  input  ADDR_W  byte address; PADDR[1:0] ignored.
REQ-008 PWDATA  input  32  write data; PSTRB  input  4  write byte strobes.
REQ-009 PRDATA  output  32  read data; PREADY  output  1  transfer complete; PSLVERR  output  1  error.
REQ-010 IRQ  output  NUM_CH  per-channel interrupt; irq_o  output  1  OR of IRQ.

Function
REQ-011 Channel i registers at base i*0x10: +0x0 CTRL, +0x4 VALUE (RO), +0x8 LOAD, +0xC STATUS.
REQ-012 CTRL fields: bit0 EN, bit1 MODE (0 periodic, 1 one-shot), bit2 IE, bits[11:8] PRESCALE; other bits read 0.
REQ-013 Global register at NUM_CH*0x10: IRQ pending vector (RO), bits above NUM_CH-1 read 0.
REQ-014 PREADY is constant 1: every transfer completes in two cycles (setup, access), no wait states.
REQ-015 Write commits on the rising edge where PSEL&PENABLE&PWRITE; byte n of CTRL/LOAD updated only if PSTRB[n].
REQ-016 PRDATA registered on the setup edge (PSEL&!PENABLE&!PWRITE) and held through access; read ignores PSTRB.
REQ-017 Address above the global register: PSLVERR=1 during access phase, PRDATA=0, no state change; PSLVERR=0 otherwise.
REQ-018 Writes to VALUE or the global register are ignored without error.
REQ-019 LOAD/VALUE are CNT_W bits; upper 32-CNT_W bits of PWDATA dropped, read back as 0.
REQ-020 Per-channel prescaler counts 0..PRESCALE while EN=1; tick asserted in the cycle prescaler==PRESCALE, then prescaler wraps to 0.
REQ-021 On tick with VALUE!=0: VALUE decrements by 1.
REQ-022 On tick with VALUE==0: STATUS.expired<=1; periodic: VALUE<=LOAD; one-shot: EN<=0, VALUE stays 0.
REQ-023 CTRL write taking EN 0->1: VALUE<=LOAD, prescaler<=0 on the same edge.
REQ-024 LOAD write while EN=0: VALUE<=new LOAD; while EN=1: VALUE unchanged, new LOAD used at next reload.
REQ-025 CTRL write with EN=0 freezes VALUE and prescaler; expired unaffected.
REQ-026 STATUS is write-1-to-clear on bit0, effective only if PSTRB[0]; set by expiry in the same cycle wins over clear.
REQ-027 IRQ[i] = expired[i] & IE[i], combinational from registers; irq_o = |IRQ.
REQ-028 Channels fully independent; simultaneous expiries in several channels all recorded.

Reset
REQ-029 PRESET_n low asynchronously clears CTRL, LOAD, VALUE, prescalers, STATUS, PRDATA to 0, including mid-count and mid-transfer.
REQ-030 During and after reset: IRQ=0, irq_o=0, PSLVERR=0, PREADY=1; first transfer accepted the cycle after PRESET_n rises.

Verification (NUM_CH=4, CNT_W=32)
REQ-031 Reset asserted mid-count -> all registers read 0, IRQ=4'b0000, PREADY=1.
REQ-032 ch0 LOAD=3, CTRL=0x5 -> VALUE 3,2,1,0, expired set and IRQ[0]=1 on 4th cycle after enable, VALUE reloads 3, period 4 cycles.
REQ-033 ch2 LOAD=2, CTRL=0x107 (one-shot, prescale 1) -> tick every 2 cycles, expired after 6 cycles, CTRL reads 0x106, VALUE stays 0.
REQ-034 ch1 LOAD=0 then write 0xabcdef12 PSTRB=4'b1101 -> LOAD reads 0xabcd0012.
REQ-035 STATUS write 0x1 in the expiry cycle -> expired stays 1; repeat in a non-expiry cycle -> expired 0, IRQ[0] falls next cycle.
REQ-036 Read/write at 0x44 -> PSLVERR=1, PRDATA=0, no register change; read 0x40 -> pending vector matches IRQ.
